ms_alu_mc: RTL and testbench



---
 rtl/ms_alu_mc.sv | 165 ++++++++++++++++
 tb/tb_ms_alu_mc.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ms_alu_mc.sv
// Multi-cycle bus ALU: operand register A, result register G, output register Q.
// Single-cycle ADD/SUB/NEG/logic/SHL plus a WIDTH-cycle shift-add multiply with Busy/Done.
module ms_alu_mc #(
    parameter int unsigned WIDTH   = 10,
    parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input  logic             CLKb,
    input  logic             Reset,
    input  logic [WIDTH-1:0] OP,
    input  logic [2:0]       ALUControl,
    input  logic             Ain,
    input  logic             Gin,
    input  logic             Gout,
    output logic [WIDTH-1:0] Q,
    output logic [3:0]       Flags,
    output logic             Busy,
    output logic             Done
);

    localparam int unsigned AW    = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_NEG = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   g_q;
    logic [WIDTH-1:0]   q_q;
    logic [3:0]         flags_q;
    logic               busy_q;
    logic               done_q;
    logic [AW-1:0]      mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [AW-1:0]      acc_q;
    logic [CNT_W-1:0]   count_q;

    logic [WIDTH-1:0]   res_c;
    logic               carry_c;
    logic               ovf_c;
    logic [WIDTH:0]     sum_c;
    logic [WIDTH-1:0]   diff_c;
    logic [WIDTH-1:0]   neg_c;
    logic [AW-1:0]      shl_c;
    logic [SHAMT_W-1:0] shamt_c;
    logic [AW-1:0]      acc_nx_c;

    // Single-cycle result and carry/overflow, evaluated against the current A.
    always_comb begin
        res_c    = '0;
        carry_c  = 1'b0;
        ovf_c    = 1'b0;
        shamt_c  = OP[SHAMT_W-1:0];
        sum_c    = {1'b0, a_q} + {1'b0, OP};
        diff_c   = a_q - OP;
        neg_c    = WIDTH'(0) - OP;
        shl_c    = AW'(a_q) << shamt_c;
        acc_nx_c = acc_q + (mplier_q[0] ? mcand_q : AW'(0));
        case (ALUControl)
            OP_ADD: begin
                res_c   = sum_c[WIDTH-1:0];
                carry_c = sum_c[WIDTH];
                ovf_c   = (a_q[WIDTH-1] == OP[WIDTH-1]) && (sum_c[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                res_c   = diff_c;
                carry_c = (a_q < OP);
                ovf_c   = (a_q[WIDTH-1] != OP[WIDTH-1]) && (diff_c[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_NEG: begin
                res_c   = neg_c;
                carry_c = (OP != '0);
                ovf_c   = (OP == {1'b1, (WIDTH-1)'(0)});
            end
            OP_AND: res_c = a_q & OP;
            OP_OR:  res_c = a_q | OP;
            OP_XOR: res_c = a_q ^ OP;
            OP_SHL: begin
                // Shifting by WIDTH or more pushes every bit of A out.
                if (32'(shamt_c) >= WIDTH) begin
                    res_c   = '0;
                    carry_c = |a_q;
                end else begin
                    res_c   = shl_c[WIDTH-1:0];
                    carry_c = |shl_c[AW-1:WIDTH];
                end
            end
            default: res_c = '0;
        endcase
    end

    // Control FSM, register file and multiply datapath.
    always_ff @(negedge CLKb) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            g_q      <= '0;
            q_q      <= '0;
            flags_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (Gout) begin
                q_q <= g_q;
            end
            case (state_q)
                S_IDLE: begin
                    if (Ain) begin
                        a_q <= OP;
                    end
                    if (Gin) begin
                        if (ALUControl == OP_MUL) begin
                            mcand_q  <= AW'(a_q);
                            mplier_q <= OP;
                            acc_q    <= '0;
                            count_q  <= '0;
                            busy_q   <= 1'b1;
                            state_q  <= S_MUL;
                        end else begin
                            g_q     <= res_c;
                            flags_q <= {(res_c == '0), res_c[WIDTH-1], carry_c, ovf_c};
                        end
                    end
                end
                S_MUL: begin
                    acc_q    <= acc_nx_c;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    count_q  <= count_q + CNT_W'(1);
                    if (count_q == CNT_W'(WIDTH - 1)) begin
                        g_q     <= acc_nx_c[WIDTH-1:0];
                        flags_q <= {(acc_nx_c[WIDTH-1:0] == '0), acc_nx_c[WIDTH-1],
                                    |acc_nx_c[AW-1:WIDTH], 1'b0};
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign Q     = q_q;
    assign Flags = flags_q;
    assign Busy  = busy_q;
    assign Done  = done_q;

endmodule

// File: tb/tb_ms_alu_mc.sv
// Scoreboard bench for ms_alu_mc: stimulus queues hand-computed Q/Flags values,
// a monitor with a small Busy/Done timing model pops and compares them.
module tb_ms_alu_mc;

    localparam int unsigned W = 10;

    localparam logic [2:0] ADD = 3'b000;
    localparam logic [2:0] SUB = 3'b001;
    localparam logic [2:0] NEG = 3'b010;
    localparam logic [2:0] AND = 3'b011;
    localparam logic [2:0] OR  = 3'b100;
    localparam logic [2:0] XOR = 3'b101;
    localparam logic [2:0] SHL = 3'b110;
    localparam logic [2:0] MUL = 3'b111;

    logic         CLKb = 1'b1;
    logic         Reset;
    logic         Ain;
    logic         Gin;
    logic         Gout;
    logic [2:0]   ALUControl;
    logic [W-1:0] OP;
    logic [W-1:0] Q;
    logic [3:0]   Flags;
    logic         Busy;
    logic         Done;

    ms_alu_mc #(.WIDTH(W)) dut (
        .CLKb       (CLKb),
        .Reset      (Reset),
        .OP         (OP),
        .ALUControl (ALUControl),
        .Ain        (Ain),
        .Gin        (Gin),
        .Gout       (Gout),
        .Q          (Q),
        .Flags      (Flags),
        .Busy       (Busy),
        .Done       (Done)
    );

    always #5 CLKb = ~CLKb;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] exp_q[$];
    logic [3:0]   exp_f[$];

    int mcnt     = 0;
    bit chk_f    = 1'b0;
    bit chk_q    = 1'b0;
    bit chk_rst  = 1'b0;
    bit exp_done = 1'b0;
    bit end_chk  = 1'b0;
    bit end_done = 1'b0;

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Decide at each active (falling) edge what the DUT should present afterwards.
    always @(negedge CLKb) begin
        chk_f    = 1'b0;
        chk_q    = 1'b0;
        chk_rst  = 1'b0;
        exp_done = 1'b0;
        if (Reset) begin
            mcnt    = 0;
            chk_rst = 1'b1;
        end else begin
            chk_q = Gout;
            if (mcnt > 0) begin
                mcnt--;
                if (mcnt == 0) begin
                    exp_done = 1'b1;
                    chk_f    = 1'b1;
                end
            end else if (Gin) begin
                if (ALUControl == MUL) mcnt = int'(W);
                else chk_f = 1'b1;
            end
        end
    end

    // Compare on the opposite edge, away from DUT updates.
    always @(posedge CLKb) begin
        check("busy", int'(Busy), (mcnt != 0) ? 1 : 0);
        check("done", int'(Done), int'(exp_done));
        if (chk_rst) begin
            check("reset_q", int'(Q), 0);
            check("reset_flags", int'(Flags), 0);
        end
        if (chk_f) begin
            if (exp_f.size() == 0) check("flags_underflow", 1, 0);
            else check("flags", int'(Flags), int'(exp_f.pop_front()));
        end
        if (chk_q) begin
            if (exp_q.size() == 0) check("q_underflow", 1, 0);
            else check("q", int'(Q), int'(exp_q.pop_front()));
        end
        if (end_chk && !end_done) begin
            check("q_leftover", exp_q.size(), 0);
            check("flags_leftover", exp_f.size(), 0);
            end_done = 1'b1;
        end
    end

    task automatic step(input logic rst, input logic ain, input logic gin, input logic gout,
                        input logic [2:0] c, input logic [W-1:0] o);
        Reset      = rst;
        Ain        = ain;
        Gin        = gin;
        Gout       = gout;
        ALUControl = c;
        OP         = o;
        @(posedge CLKb);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, ADD, '0);
    endtask

    task automatic load_a(input logic [W-1:0] v);
        step(1'b0, 1'b1, 1'b0, 1'b0, ADD, v);
    endtask

    task automatic exec(input logic [2:0] c, input logic [W-1:0] o, input logic [3:0] f);
        exp_f.push_back(f);
        step(1'b0, 1'b0, 1'b1, 1'b0, c, o);
    endtask

    task automatic xfer(input logic [W-1:0] v);
        exp_q.push_back(v);
        step(1'b0, 1'b0, 1'b0, 1'b1, ADD, '0);
    endtask

    initial begin
        // Reset overrides all strobes.
        step(1'b1, 1'b1, 1'b1, 1'b1, MUL, 10'h3FF);
        step(1'b1, 1'b1, 1'b1, 1'b1, MUL, 10'h3FF);
        xfer(10'h000);
        exec(ADD, 10'h000, 4'b1000);

        // ADD wrap-around: carry out, zero result.
        load_a(10'h3FF);
        exec(ADD, 10'h001, 4'b1010);
        xfer(10'h000);

        // SUB signed overflow, NEG of most-negative value.
        load_a(10'h200);
        exec(SUB, 10'h001, 4'b0001);
        xfer(10'h1FF);
        exec(NEG, 10'h200, 4'b0111);
        xfer(10'h200);

        // MUL 25*30; Gout during busy and on completion edge gives old G.
        load_a(10'd25);
        exp_f.push_back(4'b0100);
        step(1'b0, 1'b0, 1'b1, 1'b0, MUL, 10'd30);
        for (int i = 1; i <= 10; i++) begin
            if (i == 3 || i == 10) exp_q.push_back(10'h200);
            step(1'b0, 1'b0, 1'b0, (i == 3 || i == 10), 3'(i), 10'h3FF);
        end
        xfer(10'h2EE);

        // MUL 100*20 with overflow; Ain/Gin during busy are ignored.
        load_a(10'd100);
        exp_f.push_back(4'b0110);
        step(1'b0, 1'b0, 1'b1, 1'b0, MUL, 10'd20);
        for (int i = 1; i <= 10; i++) begin
            if (i == 3) step(1'b0, 1'b1, 1'b1, 1'b0, ADD, 10'h1FF);
            else step(1'b0, 1'b0, 1'b0, 1'b0, SUB, 10'h000);
        end
        xfer(10'h3D0);
        exec(ADD, 10'h000, 4'b0000);
        xfer(10'h064);

        // Reset during MUL aborts without a Done pulse.
        load_a(10'd5);
        step(1'b0, 1'b0, 1'b1, 1'b0, MUL, 10'd3);
        idle();
        step(1'b0, 1'b1, 1'b1, 1'b0, ADD, 10'h1FF);
        idle();
        step(1'b1, 1'b0, 1'b0, 1'b0, MUL, 10'h000);
        xfer(10'h000);
        for (int i = 0; i < 12; i++) idle();

        // Ain+Gin same edge uses old A; Gin+Gout same edge gives old G on Q.
        load_a(10'h001);
        exp_f.push_back(4'b0000);
        step(1'b0, 1'b1, 1'b1, 1'b0, ADD, 10'h007);
        xfer(10'h008);
        exp_f.push_back(4'b0000);
        exp_q.push_back(10'h008);
        step(1'b0, 1'b0, 1'b1, 1'b1, ADD, 10'h000);
        xfer(10'h007);

        // SHL with a bit shifted out, and with amount >= WIDTH.
        load_a(10'h003);
        exec(SHL, 10'h009, 4'b0110);
        xfer(10'h200);
        exec(SHL, 10'h00C, 4'b1010);
        xfer(10'h000);

        // Logic ops and ADD signed overflow.
        load_a(10'h3C3);
        exec(AND, 10'h0FF, 4'b0000);
        exec(OR,  10'h00C, 4'b0100);
        exec(XOR, 10'h3C3, 4'b1000);
        xfer(10'h000);
        load_a(10'h1FF);
        exec(ADD, 10'h001, 4'b0101);
        xfer(10'h200);

        idle();
        end_chk = 1'b1;
        idle();
        idle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
